// File: rtl/wb_dma_mem_responder_if.sv
// Bundles the CPU (wbs_*) and DMA (dma_*) Wishbone ports of the memory responder.
// Signal suffixes are given from the responder's point of view.
interface wb_dma_mem_responder_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    logic        dma_stb_i;
    logic        dma_cyc_i;
    logic        dma_we_i;
    logic [3:0]  dma_sel_i;
    logic [31:0] dma_adr_i;
    logic [31:0] dma_dat_i;
    logic        dma_ack_o;
    logic [31:0] dma_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
        output dma_ack_o, dma_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
        input  dma_ack_o, dma_dat_o
    );
endinterface

// File: rtl/wb_dma_mem_responder.sv
// Two-port (CPU/DMA) Wishbone memory responder with fixed ack latency, round-robin
// arbitration and a single outstanding transaction.
module wb_dma_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 10
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    wb_dma_mem_responder_if.slave         bus_io
);
    localparam int unsigned AddrW    = $clog2(4 * DEPTH_WORDS);
    localparam int unsigned IdxW     = AddrW - 2;
    localparam logic [31:0] WinBytes = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LastCnt  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            gnt_dma_q, last_dma_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [IdxW-1:0] idx_q;
    logic [31:0]     wdat_q;
    logic            wbs_ack_q, dma_ack_q;
    logic [31:0]     wbs_dat_q, dma_dat_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     wbs_off, dma_off;
    logic            wbs_live, dma_live, any_live, pick_dma, gnt_req;
    logic            req_we, enter_ack, ack_dma, ack_we;
    logic [3:0]      req_sel, cnt_inc;
    logic [31:0]     req_dat;
    logic [IdxW-1:0] req_idx, ack_idx;

    // Unsigned offset makes addresses below the base wrap to huge values and fail the test.
    assign wbs_off  = bus_io.wbs_adr_i - BASE_ADDR;
    assign dma_off  = bus_io.dma_adr_i - BASE_ADDR;
    assign wbs_live = bus_io.wbs_stb_i && bus_io.wbs_cyc_i && (wbs_off < WinBytes);
    assign dma_live = bus_io.dma_stb_i && bus_io.dma_cyc_i && (dma_off < WinBytes);
    assign any_live = wbs_live || dma_live;
    assign pick_dma = dma_live && (!wbs_live || !last_dma_q);

    assign req_we  = pick_dma ? bus_io.dma_we_i  : bus_io.wbs_we_i;
    assign req_sel = pick_dma ? bus_io.dma_sel_i : bus_io.wbs_sel_i;
    assign req_dat = pick_dma ? bus_io.dma_dat_i : bus_io.wbs_dat_i;
    assign req_idx = pick_dma ? bus_io.dma_adr_i[AddrW-1:2] : bus_io.wbs_adr_i[AddrW-1:2];

    assign gnt_req = gnt_dma_q ? (bus_io.dma_stb_i && bus_io.dma_cyc_i)
                               : (bus_io.wbs_stb_i && bus_io.wbs_cyc_i);
    assign cnt_inc = cnt_q + 4'd1;

    // A latency of one skips BUSY entirely, so the ack can be launched straight from IDLE.
    always_comb begin
        enter_ack = 1'b0;
        ack_dma   = gnt_dma_q;
        ack_we    = we_q;
        ack_idx   = idx_q;
        if (state_q == StIdle) begin
            enter_ack = any_live && (LATENCY == 1);
            ack_dma   = pick_dma;
            ack_we    = req_we;
            ack_idx   = req_idx;
        end else if (state_q == StBusy) begin
            enter_ack = gnt_req && (cnt_inc == LastCnt);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            gnt_dma_q  <= 1'b0;
            last_dma_q <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'd0;
            idx_q      <= '0;
            wdat_q     <= 32'd0;
            wbs_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            wbs_dat_q  <= 32'd0;
            dma_dat_q  <= 32'd0;
        end else begin
            wbs_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_live) begin
                        gnt_dma_q  <= pick_dma;
                        last_dma_q <= pick_dma;
                        we_q       <= req_we;
                        sel_q      <= req_sel;
                        idx_q      <= req_idx;
                        wdat_q     <= req_dat;
                        cnt_q      <= 4'd0;
                        state_q    <= (LATENCY == 1) ? StAck : StBusy;
                    end
                end
                StBusy: begin
                    if (!gnt_req) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == LastCnt) state_q <= StAck;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (enter_ack) begin
                if (ack_dma) begin
                    dma_ack_q <= 1'b1;
                    if (!ack_we) dma_dat_q <= mem_q[ack_idx];
                end else begin
                    wbs_ack_q <= 1'b1;
                    if (!ack_we) wbs_dat_q <= mem_q[ack_idx];
                end
            end
        end
    end

    // Storage is deliberately not reset; the write lands at the edge closing the ACK cycle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && state_q == StAck && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) mem_q[idx_q][8*i +: 8] <= wdat_q[8*i +: 8];
            end
        end
    end

    assign bus_io.wbs_ack_o = wbs_ack_q;
    assign bus_io.dma_ack_o = dma_ack_q;
    assign bus_io.wbs_dat_o = wbs_dat_q;
    assign bus_io.dma_dat_o = dma_dat_q;
endmodule

// File: tb/tb_wb_dma_mem_responder.sv
// Directed bench for wb_dma_mem_responder: vector table of single transactions plus
// hand-written arbitration, abort, window and reset sequences.
module tb_wb_dma_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_dma_mem_responder_if bus_if ();

    wb_dma_mem_responder dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus_io   (bus_if)
    );

    typedef struct {
        logic        dma;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[11];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic dma, input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat);
        if (dma) begin
            bus_if.dma_stb_i = 1'b1; bus_if.dma_cyc_i = 1'b1; bus_if.dma_we_i = we;
            bus_if.dma_sel_i = sel;  bus_if.dma_adr_i = adr;  bus_if.dma_dat_i = dat;
        end else begin
            bus_if.wbs_stb_i = 1'b1; bus_if.wbs_cyc_i = 1'b1; bus_if.wbs_we_i = we;
            bus_if.wbs_sel_i = sel;  bus_if.wbs_adr_i = adr;  bus_if.wbs_dat_i = dat;
        end
    endtask

    task automatic drop_req(input logic dma);
        if (dma) begin
            bus_if.dma_stb_i = 1'b0; bus_if.dma_cyc_i = 1'b0;
        end else begin
            bus_if.wbs_stb_i = 1'b0; bus_if.wbs_cyc_i = 1'b0;
        end
    endtask

    // Returns the number of rising edges until the port's ack is seen (0 on timeout).
    task automatic wait_ack(input logic dma, input int budget, output int lat,
                            output logic [31:0] rd, output logic other_seen);
        lat = 0; rd = 32'd0; other_seen = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); @(negedge clk);
            if (dma ? bus_if.wbs_ack_o : bus_if.dma_ack_o) other_seen = 1'b1;
            if (dma ? bus_if.dma_ack_o : bus_if.wbs_ack_o) begin
                lat = n;
                rd  = dma ? bus_if.dma_dat_o : bus_if.wbs_dat_o;
                break;
            end
        end
    endtask

    task automatic xfer(input string name, input logic dma, input logic we,
                        input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] exp_rd);
        int lat; logic [31:0] rd; logic other;
        drive_req(dma, we, sel, adr, dat);
        wait_ack(dma, 40, lat, rd, other);
        drop_req(dma);
        check({name, " latency"}, 32'(lat), 32'd10);
        check({name, " other ack"}, {31'd0, other}, 32'd0);
        if (!we) check({name, " rdata"}, rd, exp_rd);
        @(negedge clk);
    endtask

    // Both ports raise reads together; each drops its request on its own ack.
    task automatic dual(input string name, input int exp_clat, input int exp_dlat,
                        input logic [31:0] exp_crd, input logic [31:0] exp_drd);
        int clat = 0, dlat = 0, cacks = 0, dacks = 0;
        logic [31:0] crd = 32'd0, drd = 32'd0;
        drive_req(1'b0, 1'b0, 4'hF, 32'h3800_0100, 32'd0);
        drive_req(1'b1, 1'b0, 4'hF, 32'h3800_0FFC, 32'd0);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus_if.wbs_ack_o) begin
                cacks++;
                if (clat == 0) begin clat = n; crd = bus_if.wbs_dat_o; drop_req(1'b0); end
            end
            if (bus_if.dma_ack_o) begin
                dacks++;
                if (dlat == 0) begin dlat = n; drd = bus_if.dma_dat_o; drop_req(1'b1); end
            end
        end
        check({name, " cpu ack cycle"}, 32'(clat), 32'(exp_clat));
        check({name, " dma ack cycle"}, 32'(dlat), 32'(exp_dlat));
        check({name, " cpu ack count"}, 32'(cacks), 32'd1);
        check({name, " dma ack count"}, 32'(dacks), 32'd1);
        check({name, " cpu rdata"}, crd, exp_crd);
        check({name, " dma rdata"}, drd, exp_drd);
    endtask

    initial begin
        int lat, acks;
        logic [31:0] rd;
        logic other;

        vecs[0]  = '{1'b0, 1'b1, 4'hF,    32'h3800_0100, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 4'hF,    32'h3800_0100, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 4'hF,    32'h3800_0104, 32'h1122_3344, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 4'b0010, 32'h3800_0104, 32'h0000_AB00, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 4'hF,    32'h3800_0104, 32'h0,         32'h1122_AB44};
        vecs[5]  = '{1'b1, 1'b1, 4'hF,    32'h3800_0FFC, 32'hA5A5_0001, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 4'hF,    32'h3800_0FFF, 32'h0,         32'hA5A5_0001};
        vecs[7]  = '{1'b1, 1'b1, 4'b1001, 32'h3800_0104, 32'hFFFF_FFFF, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 4'hF,    32'h3800_0104, 32'h0,         32'hFF22_ABFF};
        vecs[9]  = '{1'b1, 1'b1, 4'hF,    32'h3800_0000, 32'hCAFE_0000, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 4'hF,    32'h3800_0003, 32'h0,         32'hCAFE_0000};

        drop_req(1'b0); drop_req(1'b1);
        bus_if.wbs_we_i = 1'b0; bus_if.wbs_sel_i = 4'h0; bus_if.wbs_adr_i = 32'h0;
        bus_if.wbs_dat_i = 32'h0;
        bus_if.dma_we_i = 1'b0; bus_if.dma_sel_i = 4'h0; bus_if.dma_adr_i = 32'h0;
        bus_if.dma_dat_i = 32'h0;

        repeat (2) @(negedge clk);
        check("reset wbs_ack", {31'd0, bus_if.wbs_ack_o}, 32'd0);
        check("reset dma_ack", {31'd0, bus_if.dma_ack_o}, 32'd0);
        check("reset wbs_dat", bus_if.wbs_dat_o, 32'd0);
        check("reset dma_dat", bus_if.dma_dat_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].dma, vecs[i].we, vecs[i].sel,
                 vecs[i].adr, vecs[i].dat, vecs[i].exp_rd);
        end
        check("dat_o holds after ack", bus_if.wbs_dat_o, 32'hCAFE_0000);

        // Inputs changed after acceptance must not affect the write.
        drive_req(1'b0, 1'b1, 4'hF, 32'h3800_0108, 32'h5555_AAAA);
        repeat (2) @(negedge clk);
        bus_if.wbs_dat_i = 32'h0; bus_if.wbs_sel_i = 4'h0;
        wait_ack(1'b0, 40, lat, rd, other);
        drop_req(1'b0);
        check("latched write latency", 32'(lat), 32'd8);
        @(negedge clk);
        xfer("latched readback", 1'b0, 1'b0, 4'hF, 32'h3800_0108, 32'h0, 32'h5555_AAAA);

        // Abort: CPU write dropped in BUSY; DMA read queued at the drop.
        drive_req(1'b0, 1'b1, 4'hF, 32'h3800_0100, 32'h1234_5678);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        check("abort no ack in busy", {31'd0, bus_if.wbs_ack_o}, 32'd0);
        drop_req(1'b0);
        drive_req(1'b1, 1'b0, 4'hF, 32'h3800_0100, 32'h0);
        wait_ack(1'b1, 40, lat, rd, other);
        drop_req(1'b1);
        check("abort follow-up latency", 32'(lat), 32'd11);
        check("abort cpu never acked", {31'd0, other}, 32'd0);
        check("abort word unchanged", rd, 32'hDEAD_BEEF);
        @(negedge clk);

        // Out-of-window request stays unacked and does not occupy the FSM.
        drive_req(1'b0, 1'b0, 4'hF, 32'h3800_1000, 32'h0);
        acks = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus_if.wbs_ack_o) acks++;
        end
        check("out of window no ack", 32'(acks), 32'd0);
        drive_req(1'b1, 1'b0, 4'hF, 32'h3800_0FFC, 32'h0);
        wait_ack(1'b1, 40, lat, rd, other);
        drop_req(1'b1); drop_req(1'b0);
        check("idle after window miss", 32'(lat), 32'd10);
        check("window miss still unacked", {31'd0, other}, 32'd0);
        @(negedge clk);

        // Reset during a DMA write's BUSY phase cancels it.
        drive_req(1'b1, 1'b1, 4'hF, 32'h3800_0100, 32'h0000_0000);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        drop_req(1'b1);
        acks = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus_if.dma_ack_o) acks++;
        end
        check("reset cancel no dma ack", 32'(acks), 32'd0);

        // First simultaneous grant after reset goes to DMA; memory survived reset.
        dual("rr after reset", 21, 10, 32'hDEAD_BEEF, 32'hA5A5_0001);
        check("dma dat holds", bus_if.dma_dat_o, 32'hA5A5_0001);
        @(negedge clk);
        xfer("dma single", 1'b1, 1'b0, 4'hF, 32'h3800_0104, 32'h0, 32'hFF22_ABFF);
        dual("rr after dma", 10, 21, 32'hDEAD_BEEF, 32'hA5A5_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_dma_mem_responder.md
WB_DMA_MEM_RESPONDER -- requirements
Module: wb_dma_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3800_0000: base of the responder's memory window.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: 32-bit words of internal storage; window size is 4*DEPTH_WORDS bytes.
REQ-003 SHALL have parameter LATENCY, default 10: cycles from request acceptance to ack; legal range 1..15.
REQ-004 SHALL have the port wb_clk_i, input, 1 bit: single clock for all logic.
REQ-005 SHALL have the port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have the CPU port inputs wbs_stb_i (1), wbs_cyc_i (1), wbs_we_i (1), wbs_sel_i (4), wbs_adr_i (32) and wbs_dat_i (32).
REQ-007 SHALL have the CPU port outputs wbs_ack_o (1, single-cycle ack) and wbs_dat_o (32, read data).
REQ-008 SHALL have the DMA port inputs dma_stb_i (1), dma_cyc_i (1), dma_we_i (1), dma_sel_i (4), dma_adr_i (32) and dma_dat_i (32).
REQ-009 SHALL have the DMA port outputs dma_ack_o (1, single-cycle ack) and dma_dat_o (32, read data).

Function
REQ-010 A request on a port SHALL be live when stb and cyc are both 1 and (adr - BASE_ADDR) < 4*DEPTH_WORDS; requests outside the window SHALL never be acked.
REQ-011 The word index SHALL be adr[log2(4*DEPTH_WORDS)-1:2]; adr[1:0] SHALL be ignored.
REQ-012 FSM states SHALL be IDLE, BUSY and ACK, with a single outstanding transaction.
REQ-013 In IDLE with one live request, the FSM SHALL grant that port, latch we/sel/adr/dat, clear the counter and go to BUSY.
REQ-014 In IDLE with both ports live, the FSM SHALL grant the port not granted last (round-robin); the first grant after reset SHALL go to DMA.
REQ-015 In BUSY, the counter SHALL increment each cycle; when counter == LATENCY-1, the FSM SHALL go to ACK.
REQ-016 Ack timing: a request accepted in cycle t SHALL see its ack high in cycle t+LATENCY for exactly one cycle, and only on the granted port.
REQ-017 In ACK, a read SHALL drive the granted port's dat_o with mem[index] in the same cycle as ack.
REQ-018 In ACK, a write SHALL update each byte lane i where sel[i]=1, at the clock edge ending the ACK cycle; bytes with sel[i]=0 SHALL be unchanged.
REQ-019 After ACK, the FSM SHALL return to IDLE; a back-to-back request SHALL NOT be accepted in the ACK cycle itself, so minimum spacing is LATENCY+1 cycles.
REQ-020 Abort: if the granted port drops stb or cyc during BUSY, the FSM SHALL return to IDLE next cycle with no ack and no memory write.
REQ-021 The non-granted port's ack SHALL stay 0, and its request SHALL wait, not be lost, while it remains asserted.
REQ-022 dat_o of a port SHALL hold its last driven value when that port is not acking; it SHALL be 0 after reset.
REQ-023 Writes SHALL use the latched dat/sel; master changes to inputs after acceptance SHALL have no effect.
REQ-024 A write and a read to the same word from different ports SHALL be serialized in grant order; the later access SHALL observe the earlier write.

Reset
REQ-025 While wb_rst_i=1 at a clock edge: state SHALL be IDLE, counter 0, wbs_ack_o=dma_ack_o=0, wbs_dat_o=dma_dat_o=0, and last-grant SHALL be set so that DMA wins next.
REQ-026 Reset asserted mid-BUSY SHALL cancel the transaction: no ack and no write.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-028 CPU write adr 0x3800_0100, dat 0xDEAD_BEEF, sel 4'hF, then CPU read of the same address -> ack 10 cycles after each acceptance; read returns 0xDEAD_BEEF.
REQ-029 Partial write sel 4'b0010, dat 0x0000_AB00 over word 0x1122_3344 at 0x3800_0104 -> readback 0x1122_AB44.
REQ-030 CPU and DMA reads raised in the same cycle after reset -> DMA acked at t+10; CPU accepted at t+11 and acked at t+21; wbs_ack_o stays 0 until then.
REQ-031 CPU write abort (stb dropped at cycle 5 of BUSY) -> no ack; target word unchanged; next request accepted the following cycle.
REQ-032 Read at 0x3800_1000 (out of window, DEPTH_WORDS=1024) -> no ack for 50 cycles; FSM remains in IDLE.
REQ-033 Reset pulse during a DMA write's BUSY phase -> no dma_ack_o, memory unchanged; a post-reset read returns the old data.
